// File: rtl/core_sequencer_if.sv
// core_sequencer_if: start/halt control, instruction and data memory
// handshakes, decoder results and debug status for the core sequencer.
interface core_sequencer_if;
   logic        start_i;
   logic        halt_req_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] inst_o;
   logic        dec_n_inst_i;
   logic        dec_is_load_i;
   logic        dec_is_store_i;
   logic        dec_is_branch_i;
   logic [31:0] dec_imm_i;
   logic [4:0]  dec_rd_num_i;
   logic        br_taken_i;
   logic        exec_en_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic        dmem_ack_i;
   logic        rf_we_o;
   logic [31:0] pc_o;
   logic [2:0]  state_o;
   logic        trap_o;
   logic [1:0]  trap_cause_o;
   logic [31:0] retire_cnt_o;

   modport master (
      input  start_i, halt_req_i, imem_ack_i, imem_rdata_i,
      input  dec_n_inst_i, dec_is_load_i, dec_is_store_i,
      input  dec_is_branch_i, dec_imm_i, dec_rd_num_i,
      input  br_taken_i, dmem_ack_i,
      output imem_req_o, imem_addr_o, inst_o, exec_en_o,
      output dmem_req_o, dmem_we_o, rf_we_o, pc_o, state_o,
      output trap_o, trap_cause_o, retire_cnt_o
   );

   modport slave (
      output start_i, halt_req_i, imem_ack_i, imem_rdata_i,
      output dec_n_inst_i, dec_is_load_i, dec_is_store_i,
      output dec_is_branch_i, dec_imm_i, dec_rd_num_i,
      output br_taken_i, dmem_ack_i,
      input  imem_req_o, imem_addr_o, inst_o, exec_en_o,
      input  dmem_req_o, dmem_we_o, rf_we_o, pc_o, state_o,
      input  trap_o, trap_cause_o, retire_cnt_o
   );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM.
// Owns the PC, the retired-instruction counter and the sticky trap.
module core_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned DEC_LAT      = 2,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input logic              clk,
   input logic              rst_n,
   core_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_e;

   localparam logic [1:0]  C_TMO = 2'b01;
   localparam logic [1:0]  C_ILL = 2'b10;
   localparam logic [1:0]  C_MIS = 2'b11;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] DEC_LAST = DEC_LAT - 1;
   localparam logic [31:0] TMO_LAST = MEM_TIMEOUT - 1;

   state_e      state_q;
   logic [31:0] pc_q, npc_q, inst_q, imm_q, ret_q;
   logic [31:0] tmo_q, dcnt_q;
   logic [4:0]  rd_q;
   logic        ld_q, st_q, br_q;
   logic        imem_req_q, exec_en_q, dmem_req_q, dmem_we_q;
   logic        rf_we_q, trap_q;
   logic [1:0]  cause_q;

   logic [31:0] npc_d;
   logic        rf_we_d, tmo_hit, dec_last;

   assign npc_d    = (br_q && bus.br_taken_i) ? pc_q + imm_q
                                              : pc_q + 32'd4;
   assign rf_we_d  = !br_q && !st_q && (rd_q != 5'd0);
   assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);
   assign dec_last = (dcnt_q == DEC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_VECTOR;
         npc_q      <= RESET_VECTOR;
         inst_q     <= NOP;
         imm_q      <= '0;
         rd_q       <= '0;
         ld_q       <= 1'b0;
         st_q       <= 1'b0;
         br_q       <= 1'b0;
         ret_q      <= '0;
         tmo_q      <= '0;
         dcnt_q     <= '0;
         imem_req_q <= 1'b0;
         exec_en_q  <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         rf_we_q    <= 1'b0;
         trap_q     <= 1'b0;
         cause_q    <= 2'b00;
      end else begin
         exec_en_q <= 1'b0;
         rf_we_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  if (pc_q[1:0] != 2'b00) begin
                     state_q <= S_TRAP;
                     trap_q  <= 1'b1;
                     cause_q <= C_MIS;
                  end else begin
                     state_q    <= S_FETCH;
                     imem_req_q <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (bus.imem_ack_i) begin
                  inst_q     <= bus.imem_rdata_i;
                  imem_req_q <= 1'b0;
                  tmo_q      <= '0;
                  dcnt_q     <= '0;
                  state_q    <= S_DECODE;
               end else if (tmo_hit) begin
                  imem_req_q <= 1'b0;
                  tmo_q      <= '0;
                  state_q    <= S_TRAP;
                  trap_q     <= 1'b1;
                  cause_q    <= C_TMO;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            S_DECODE: begin
               if (dec_last) begin
                  dcnt_q <= '0;
                  if (bus.dec_n_inst_i) begin
                     state_q <= S_TRAP;
                     trap_q  <= 1'b1;
                     cause_q <= C_ILL;
                  end else begin
                     ld_q      <= bus.dec_is_load_i;
                     st_q      <= bus.dec_is_store_i;
                     br_q      <= bus.dec_is_branch_i;
                     imm_q     <= bus.dec_imm_i;
                     rd_q      <= bus.dec_rd_num_i;
                     exec_en_q <= 1'b1;
                     state_q   <= S_EXEC;
                  end
               end else begin
                  dcnt_q <= dcnt_q + 32'd1;
               end
            end
            S_EXEC: begin
               npc_q <= npc_d;
               if (ld_q || st_q) begin
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= st_q;
                  state_q    <= S_MEM;
               end else begin
                  rf_we_q <= rf_we_d;
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (bus.dmem_ack_i) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  tmo_q      <= '0;
                  rf_we_q    <= rf_we_d;
                  state_q    <= S_WB;
               end else if (tmo_hit) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  tmo_q      <= '0;
                  state_q    <= S_TRAP;
                  trap_q     <= 1'b1;
                  cause_q    <= C_TMO;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            S_WB: begin
               pc_q  <= npc_q;
               ret_q <= ret_q + 32'd1;
               // misalignment is caught before any request is issued
               if (bus.halt_req_i) begin
                  state_q <= S_IDLE;
               end else if (npc_q[1:0] != 2'b00) begin
                  state_q <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= C_MIS;
               end else begin
                  imem_req_q <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_TRAP: state_q <= S_TRAP;
            default: state_q <= S_TRAP;
         endcase
      end
   end

   assign bus.imem_req_o   = imem_req_q;
   assign bus.imem_addr_o  = pc_q;
   assign bus.inst_o       = inst_q;
   assign bus.exec_en_o    = exec_en_q;
   assign bus.dmem_req_o   = dmem_req_q;
   assign bus.dmem_we_o    = dmem_we_q;
   assign bus.rf_we_o      = rf_we_q;
   assign bus.pc_o         = pc_q;
   assign bus.state_o      = state_q;
   assign bus.trap_o       = trap_q;
   assign bus.trap_cause_o = cause_q;
   assign bus.retire_cnt_o = ret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven instruction runs plus hand sequences
// for halt/resume, traps, timeout and reset during a data access.
module tb_core_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   core_sequencer_if bus ();

   core_sequencer #(
      .RESET_VECTOR(32'h0000_0000),
      .DEC_LAT(2),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      bit          n_inst, ld, st, br, taken;
      logic [31:0] imm;
      logic [4:0]  rd;
      int          iwait, dwait;
      bit          halt, pre_start, stop_mem;
      logic [31:0] exp_pc;
      int          exp_rfwe, exp_exec, exp_wb, exp_dreq, exp_dwe;
      logic [2:0]  exp_state;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];
   vec_t h;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_fetch;
   int r_exec, r_exec_n, r_wb, r_rfwe_n, r_dreq, r_dwe, r_ireq, r_end;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, bus.state_o, 32'd0);
      chk({tag, "_pc"}, bus.pc_o, 32'h0);
      chk({tag, "_inst"}, bus.inst_o, 32'h13);
      chk({tag, "_trap"}, {bus.trap_o, bus.trap_cause_o}, 32'd0);
      chk({tag, "_ret"}, bus.retire_cnt_o, 32'd0);
      chk({tag, "_strb"}, {bus.imem_req_o, bus.exec_en_o,
          bus.dmem_req_o, bus.dmem_we_o, bus.rf_we_o}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      step();
      rst_n = 1'b1;
      exp_fetch = 32'h0;
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
   endtask

   task automatic run(input vec_t v);
      int c, iw, dw, g;
      bit done;
      c = 0; iw = 0; dw = 0; g = 0; done = 0;
      r_exec = -1; r_exec_n = 0; r_wb = -1; r_rfwe_n = 0;
      r_dreq = 0; r_dwe = 0; r_ireq = 0;
      bus.imem_rdata_i    = v.rdata;
      bus.dec_n_inst_i    = v.n_inst;
      bus.dec_is_load_i   = v.ld;
      bus.dec_is_store_i  = v.st;
      bus.dec_is_branch_i = v.br;
      bus.dec_imm_i       = v.imm;
      bus.dec_rd_num_i    = v.rd;
      bus.br_taken_i      = v.taken;
      while (bus.state_o != 3'd1 && g < 20) begin
         step();
         g++;
      end
      chk("fetch_seen", bus.state_o, 32'd1);
      chk("fetch_addr", bus.imem_addr_o, exp_fetch);
      while (!done && c < 60) begin
         if (bus.state_o == 3'd7) begin
            done = 1;
         end else if (v.stop_mem && bus.dmem_req_o) begin
            done = 1;
         end else begin
            if (bus.exec_en_o) begin
               r_exec = c;
               r_exec_n++;
            end
            if (bus.rf_we_o) r_rfwe_n++;
            if (bus.imem_req_o) begin
               r_ireq++;
               bus.imem_ack_i = (iw == v.iwait);
               iw++;
            end
            if (bus.dmem_req_o) begin
               r_dreq++;
               if (bus.dmem_we_o) r_dwe++;
               bus.dmem_ack_i = (dw == v.dwait);
               dw++;
            end
            if (bus.state_o == 3'd5) begin
               r_wb = c;
               bus.halt_req_i = v.halt;
               done = 1;
            end
            step();
            bus.halt_req_i = 1'b0;
            bus.imem_ack_i = 1'b0;
            bus.dmem_ack_i = 1'b0;
            c++;
         end
      end
      r_end = c;
      chk("run_bound", {31'd0, done}, 32'd1);
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.halt_req_i = 1'b0;
      bus.imem_ack_i = 1'b1;
      bus.imem_rdata_i = 32'h0;
      bus.dec_n_inst_i = 1'b0;
      bus.dec_is_load_i = 1'b0;
      bus.dec_is_store_i = 1'b0;
      bus.dec_is_branch_i = 1'b0;
      bus.dec_imm_i = 32'h0;
      bus.dec_rd_num_i = 5'd0;
      bus.br_taken_i = 1'b0;
      bus.dmem_ack_i = 1'b1;
      exp_fetch = 32'h0;

      // rdata n ld st br tk imm rd iw dw halt pre stop | pc rfwe exec wb dreq dwe state
      tbl[0]  = '{32'h00100093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 5'd1,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'h04, 1, 3, 4, 0, 0, 3'd1};
      tbl[1]  = '{32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'h08, 0, 3, 4, 0, 0, 3'd1};
      tbl[2]  = '{32'h0000a283, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'h0C, 1, 3, 5, 1, 0, 3'd1};
      tbl[3]  = '{32'h00200113, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2, 5'd2,
                  2, 0, 1'b0, 1'b0, 1'b0, 32'h10, 1, 5, 6, 0, 0, 3'd1};
      tbl[4]  = '{32'hfe000ce3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8,
                  5'd3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h08, 0, 3, 4, 0, 0, 3'd1};
      tbl[5]  = '{32'hfe000ce3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF8,
                  5'd3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0C, 0, 3, 4, 0, 0, 3'd1};
      tbl[6]  = '{32'h00702023, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd7,
                  0, 3, 1'b0, 1'b0, 1'b0, 32'h10, 0, 3, 8, 4, 4, 3'd1};
      tbl[7]  = '{32'h00208233, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 5'd4,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'h14, 1, 3, 4, 0, 0, 3'd1};
      tbl[8]  = '{32'h00100093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 5'd1,
                  0, 0, 1'b1, 1'b0, 1'b0, 32'h18, 1, 3, 4, 0, 0, 3'd0};
      tbl[9]  = '{32'h00300193, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3, 5'd3,
                  1, 0, 1'b0, 1'b1, 1'b0, 32'h1C, 1, 4, 5, 0, 0, 3'd1};
      tbl[10] = '{32'h00000163, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2, 5'd0,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'h1E, 0, 3, 4, 0, 0, 3'd7};

      #12;
      chk_reset("rst0");
      step();
      rst_n = 1'b1;
      bus.imem_ack_i = 1'b0;
      bus.dmem_ack_i = 1'b0;
      pulse_start();

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].pre_start) begin
            bus.halt_req_i = 1'b1;
            bus.imem_ack_i = 1'b1;
            bus.dmem_ack_i = 1'b1;
            repeat (3) step();
            bus.halt_req_i = 1'b0;
            bus.imem_ack_i = 1'b0;
            bus.dmem_ack_i = 1'b0;
            chk($sformatf("v%0d_idle", i), bus.state_o, 32'd0);
            chk($sformatf("v%0d_idlereq", i), bus.imem_req_o, 32'd0);
            pulse_start();
         end
         run(tbl[i]);
         chk($sformatf("v%0d_exec", i), r_exec, tbl[i].exp_exec);
         chk($sformatf("v%0d_execn", i), r_exec_n, 32'd1);
         chk($sformatf("v%0d_wb", i), r_wb, tbl[i].exp_wb);
         chk($sformatf("v%0d_rfwe", i), r_rfwe_n, tbl[i].exp_rfwe);
         chk($sformatf("v%0d_dreq", i), r_dreq, tbl[i].exp_dreq);
         chk($sformatf("v%0d_dwe", i), r_dwe, tbl[i].exp_dwe);
         chk($sformatf("v%0d_state", i), bus.state_o, tbl[i].exp_state);
         chk($sformatf("v%0d_pc", i), bus.pc_o, tbl[i].exp_pc);
         chk($sformatf("v%0d_ret", i), bus.retire_cnt_o, i + 1);
         chk($sformatf("v%0d_inst", i), bus.inst_o, tbl[i].rdata);
         exp_fetch = tbl[i].exp_pc;
      end

      chk("mis_trap", {bus.trap_o, bus.trap_cause_o}, 32'b111);
      chk("mis_req", bus.imem_req_o, 32'd0);
      pulse_start();
      step();
      chk("mis_sticky", bus.state_o, 32'd7);
      chk("mis_pc_hold", bus.pc_o, 32'h1E);

      do_reset();
      chk_reset("rst1");

      pulse_start();
      h = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0,
            0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 3'd7};
      run(h);
      chk("ill_end", r_end, 32'd3);
      chk("ill_exec", r_exec_n, 32'd0);
      chk("ill_trap", {bus.trap_o, bus.trap_cause_o}, 32'b110);
      chk("ill_pc", bus.pc_o, 32'h0);
      chk("ill_inst", bus.inst_o, 32'hFFFFFFFF);
      bus.start_i = 1'b1;
      repeat (3) step();
      bus.start_i = 1'b0;
      chk("ill_sticky", bus.state_o, 32'd7);
      chk("ill_noreq", bus.imem_req_o, 32'd0);

      do_reset();
      pulse_start();
      h = '{32'h00100093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd1,
            99, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 3'd7};
      run(h);
      chk("tmo_end", r_end, 32'd4);
      chk("tmo_ireq", r_ireq, 32'd4);
      chk("tmo_trap", {bus.trap_o, bus.trap_cause_o}, 32'b101);
      chk("tmo_drop", bus.imem_req_o, 32'd0);
      chk("tmo_pc", bus.pc_o, 32'h0);

      do_reset();
      pulse_start();
      run(tbl[0]);
      chk("rm_pc0", bus.pc_o, 32'h4);
      exp_fetch = 32'h4;
      h = tbl[2];
      h.stop_mem = 1'b1;
      run(h);
      chk("rm_inmem", {bus.state_o, bus.dmem_req_o}, {28'd0, 3'd4, 1'b1});
      rst_n = 1'b0;
      #1;
      chk_reset("rm");
      #2;
      rst_n = 1'b1;
      bus.imem_ack_i = 1'b1;
      bus.dmem_ack_i = 1'b1;
      repeat (3) step();
      bus.imem_ack_i = 1'b0;
      bus.dmem_ack_i = 1'b0;
      chk("rm_idle", bus.state_o, 32'd0);
      chk("rm_noreq", {bus.imem_req_o, bus.dmem_req_o}, 32'd0);
      chk("rm_ret", bus.retire_cnt_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
